// File: rtl/router_pkg.sv
// Shared router definitions: data width default, header field layout and the
// router FSM state encoding used by the FSM and its datapath.
package router_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned ADDR_MSB = 1;
    localparam int unsigned LEN_LSB  = 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

endpackage

// File: rtl/router_parity_chk.sv
// Packet parity tracker: accumulates internal parity, captures the trailing
// parity byte (direct or from the hold register) and flags a mismatch.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_detect_addr,
    input  logic             i_lfd_state,
    input  logic             i_ld_state,
    input  logic             i_laf_state,
    input  logic             i_rst_int_reg,
    input  logic             i_pkt_valid,
    input  logic             i_fifo_full,
    input  logic             i_low_pkt_valid,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic [WIDTH-1:0] i_header,
    input  logic [WIDTH-1:0] i_hold,
    output logic             o_parity_done,
    output logic             o_err
);

    logic [WIDTH-1:0] r_int_parity;
    logic [WIDTH-1:0] r_pkt_parity;
    logic             r_parity_done;
    logic             r_err;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_int_parity <= '0;
        end else if (i_detect_addr) begin
            r_int_parity <= '0;
        end else if (i_lfd_state) begin
            r_int_parity <= r_int_parity ^ i_header;
        end else if (i_ld_state && i_pkt_valid) begin
            r_int_parity <= r_int_parity ^ i_data_in;
        end
    end

    // Parity byte arrives either directly in load, or parked in hold when the
    // FIFO was full; !r_parity_done keeps the parked copy from landing twice.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_pkt_parity  <= '0;
            r_parity_done <= 1'b0;
        end else if (i_detect_addr) begin
            r_parity_done <= 1'b0;
        end else if (i_ld_state && !i_fifo_full && !i_pkt_valid) begin
            r_pkt_parity  <= i_data_in;
            r_parity_done <= 1'b1;
        end else if (i_laf_state && i_low_pkt_valid && !r_parity_done) begin
            r_pkt_parity  <= i_hold;
            r_parity_done <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_err <= 1'b0;
        end else if (i_detect_addr && i_pkt_valid) begin
            r_err <= 1'b0;
        end else if (i_rst_int_reg && r_parity_done) begin
            r_err <= (r_int_parity != r_pkt_parity);
        end
    end

    assign o_parity_done = r_parity_done;
    assign o_err         = r_err;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, full-FIFO hold byte, registered
// FIFO write data and low-pkt-valid flag; parity handled by router_parity_chk.
module router_reg
    import router_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_full,
    input  logic             detect_addr,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             lfd_state,
    input  logic             rst_int_reg,
    output logic [WIDTH-1:0] dout,
    output logic             parity_done,
    output logic             low_pkt_valid,
    output logic             err
);

    logic [WIDTH-1:0] r_header;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_dout;
    logic             r_low_pkt_valid;
    logic             w_full_state_unused;

    // full_state needs no action here: dout simply holds while the FSM waits.
    assign w_full_state_unused = full_state;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_header <= '0;
        end else if (detect_addr && pkt_valid) begin
            r_header <= data_in;
        end
    end

    // The source considers this byte accepted, so park it until load-after-full.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hold <= '0;
        end else if (ld_state && fifo_full) begin
            r_hold <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_dout <= '0;
        end else if (lfd_state) begin
            r_dout <= r_header;
        end else if (ld_state && !fifo_full) begin
            r_dout <= data_in;
        end else if (laf_state) begin
            r_dout <= r_hold;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            r_low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            r_low_pkt_valid <= 1'b1;
        end
    end

    router_parity_chk #(
        .WIDTH(WIDTH)
    ) u_parity_chk (
        .i_clk          (clk),
        .i_resetn       (resetn),
        .i_detect_addr  (detect_addr),
        .i_lfd_state    (lfd_state),
        .i_ld_state     (ld_state),
        .i_laf_state    (laf_state),
        .i_rst_int_reg  (rst_int_reg),
        .i_pkt_valid    (pkt_valid),
        .i_fifo_full    (fifo_full),
        .i_low_pkt_valid(r_low_pkt_valid),
        .i_data_in      (data_in),
        .i_header       (r_header),
        .i_hold         (r_hold),
        .o_parity_done  (parity_done),
        .o_err          (err)
    );

    assign dout          = r_dout;
    assign low_pkt_valid = r_low_pkt_valid;

endmodule

// File: tb/tb_router_reg.sv
// Bench for router_reg: cycle vectors with hand-derived expected outputs,
// queued when driven and compared once the DUT has clocked them.
module tb_router_reg;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_DA   = 6'b100000;
    localparam logic [5:0] S_LFD  = 6'b010000;
    localparam logic [5:0] S_LD   = 6'b001000;
    localparam logic [5:0] S_FS   = 6'b000100;
    localparam logic [5:0] S_LAF  = 6'b000010;
    localparam logic [5:0] S_RI   = 6'b000001;

    typedef struct {
        logic       rstn;
        logic [5:0] st;
        logic       pv;
        logic [7:0] d;
        logic       full;
        logic [7:0] e_dout;
        logic       e_pd;
        logic       e_low;
        logic       e_err;
    } vec_t;

    typedef struct {
        int unsigned idx;
        logic [7:0]  dout;
        logic        pd;
        logic        low;
        logic        err;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_addr, ld_state, laf_state, full_state, lfd_state, rst_int_reg;
    logic [7:0] dout;
    logic       parity_done, low_pkt_valid, err;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned step_no = 0;
    exp_t        sb[$];
    vec_t        vecs[$];

    always #5 clk = ~clk;

    router_reg #(.WIDTH(8)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .detect_addr  (detect_addr),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .lfd_state    (lfd_state),
        .rst_int_reg  (rst_int_reg),
        .dout         (dout),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .err          (err)
    );

    task automatic check(input string name, input int unsigned idx,
                         input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, required %h", name, idx, act, req);
        end
    endtask

    task automatic step(input logic rstn, input logic [5:0] st, input logic pv,
                        input logic [7:0] d, input logic full,
                        input logic [7:0] e_dout, input logic e_pd,
                        input logic e_low, input logic e_err);
        exp_t e;
        resetn = rstn;
        {detect_addr, lfd_state, ld_state, full_state, laf_state, rst_int_reg} = st;
        pkt_valid = pv;
        data_in   = d;
        fifo_full = full;
        e.idx = step_no; e.dout = e_dout; e.pd = e_pd; e.low = e_low; e.err = e_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard step %0d: got empty queue, required entry", step_no);
        end else begin
            e = sb.pop_front();
            check("dout",          e.idx, dout,                 e.dout);
            check("parity_done",   e.idx, {7'd0, parity_done},   {7'd0, e.pd});
            check("low_pkt_valid", e.idx, {7'd0, low_pkt_valid}, {7'd0, e.low});
            check("err",           e.idx, {7'd0, err},           {7'd0, e.err});
        end
        step_no++;
    endtask

    function automatic vec_t v(input logic rstn, input logic [5:0] st, input logic pv,
                               input logic [7:0] d, input logic full,
                               input logic [7:0] ed, input logic ep,
                               input logic el, input logic ee);
        vec_t r;
        r.rstn = rstn; r.st = st; r.pv = pv; r.d = d; r.full = full;
        r.e_dout = ed; r.e_pd = ep; r.e_low = el; r.e_err = ee;
        return r;
    endfunction

    initial begin
        // reset
        vecs.push_back(v(0, S_NONE, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        // clean packet 09 A1 B2 / 1A
        vecs.push_back(v(1, S_DA,   1, 8'h09, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(1, S_LFD,  1, 8'hA1, 0, 8'h09, 0, 0, 0));
        vecs.push_back(v(1, S_LD,   1, 8'hA1, 0, 8'hA1, 0, 0, 0));
        vecs.push_back(v(1, S_LD,   1, 8'hB2, 0, 8'hB2, 0, 0, 0));
        vecs.push_back(v(1, S_LD,   0, 8'h1A, 0, 8'h1A, 1, 1, 0));
        vecs.push_back(v(1, S_NONE, 0, 8'h00, 0, 8'h1A, 1, 1, 0));
        vecs.push_back(v(1, S_RI,   0, 8'h00, 0, 8'h1A, 1, 0, 0));
        vecs.push_back(v(1, S_NONE, 0, 8'h00, 0, 8'h1A, 1, 0, 0));
        // bad parity 1B; err sticks until header with pkt_valid
        vecs.push_back(v(1, S_DA,   1, 8'h09, 0, 8'h1A, 0, 0, 0));
        vecs.push_back(v(1, S_LFD,  1, 8'hA1, 0, 8'h09, 0, 0, 0));
        vecs.push_back(v(1, S_LD,   1, 8'hA1, 0, 8'hA1, 0, 0, 0));
        vecs.push_back(v(1, S_LD,   1, 8'hB2, 0, 8'hB2, 0, 0, 0));
        vecs.push_back(v(1, S_LD,   0, 8'h1B, 0, 8'h1B, 1, 1, 0));
        vecs.push_back(v(1, S_NONE, 0, 8'h00, 0, 8'h1B, 1, 1, 0));
        vecs.push_back(v(1, S_RI,   0, 8'h00, 0, 8'h1B, 1, 0, 1));
        vecs.push_back(v(1, S_NONE, 0, 8'h00, 0, 8'h1B, 1, 0, 1));
        vecs.push_back(v(1, S_DA,   0, 8'h00, 0, 8'h1B, 0, 0, 1));
        vecs.push_back(v(1, S_DA,   1, 8'h09, 0, 8'h1B, 0, 0, 0));
        // full during A1, three full_state cycles, then laf
        vecs.push_back(v(1, S_LFD,  1, 8'hA1, 0, 8'h09, 0, 0, 0));
        vecs.push_back(v(1, S_LD,   1, 8'hA1, 1, 8'h09, 0, 0, 0));
        vecs.push_back(v(1, S_FS,   1, 8'hB2, 1, 8'h09, 0, 0, 0));
        vecs.push_back(v(1, S_FS,   1, 8'hB2, 1, 8'h09, 0, 0, 0));
        vecs.push_back(v(1, S_FS,   1, 8'hB2, 0, 8'h09, 0, 0, 0));
        vecs.push_back(v(1, S_LAF,  1, 8'hB2, 0, 8'hA1, 0, 0, 0));
        vecs.push_back(v(1, S_LD,   1, 8'hB2, 0, 8'hB2, 0, 0, 0));
        vecs.push_back(v(1, S_LD,   0, 8'h1A, 0, 8'h1A, 1, 1, 0));
        vecs.push_back(v(1, S_NONE, 0, 8'h00, 0, 8'h1A, 1, 1, 0));
        vecs.push_back(v(1, S_RI,   0, 8'h00, 0, 8'h1A, 1, 0, 0));
        // full on the parity byte: captured from hold in laf
        vecs.push_back(v(1, S_DA,   1, 8'h09, 0, 8'h1A, 0, 0, 0));
        vecs.push_back(v(1, S_LFD,  1, 8'hA1, 0, 8'h09, 0, 0, 0));
        vecs.push_back(v(1, S_LD,   1, 8'hA1, 0, 8'hA1, 0, 0, 0));
        vecs.push_back(v(1, S_LD,   1, 8'hB2, 0, 8'hB2, 0, 0, 0));
        vecs.push_back(v(1, S_LD,   0, 8'h1A, 1, 8'hB2, 0, 1, 0));
        vecs.push_back(v(1, S_FS,   0, 8'h00, 1, 8'hB2, 0, 1, 0));
        vecs.push_back(v(1, S_LAF,  0, 8'h00, 0, 8'h1A, 1, 1, 0));
        vecs.push_back(v(1, S_NONE, 0, 8'h00, 0, 8'h1A, 1, 1, 0));
        vecs.push_back(v(1, S_RI,   0, 8'h00, 0, 8'h1A, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rstn, vecs[i].st, vecs[i].pv, vecs[i].d, vecs[i].full,
                 vecs[i].e_dout, vecs[i].e_pd, vecs[i].e_low, vecs[i].e_err);
        end

        // reset mid-payload, then packet 05 3C / 39
        step(1, S_DA,   1, 8'h09, 0, 8'h1A, 0, 0, 0);
        step(1, S_LFD,  1, 8'hA1, 0, 8'h09, 0, 0, 0);
        step(1, S_LD,   0, 8'hA1, 0, 8'hA1, 1, 1, 0);
        step(0, S_LD,   1, 8'hB2, 0, 8'h00, 0, 0, 0);
        step(1, S_DA,   1, 8'h05, 0, 8'h00, 0, 0, 0);
        step(1, S_LFD,  1, 8'h3C, 0, 8'h05, 0, 0, 0);
        step(1, S_LD,   1, 8'h3C, 0, 8'h3C, 0, 0, 0);
        step(1, S_LD,   0, 8'h39, 0, 8'h39, 1, 1, 0);
        step(1, S_NONE, 0, 8'h00, 0, 8'h39, 1, 1, 0);
        step(1, S_RI,   0, 8'h00, 0, 8'h39, 1, 0, 0);

        // stray parity byte 55 against internal 39: low set, then rst_int clears it and flags err
        step(1, S_LD,   0, 8'h55, 0, 8'h55, 1, 1, 0);
        step(1, S_RI,   0, 8'h00, 0, 8'h55, 1, 0, 1);
        step(1, S_DA,   1, 8'h0D, 0, 8'h55, 0, 0, 0);

        if (sb.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/router_reg.md
# router_reg

Datapath register stage of the 1x3 packet router, directly downstream of the router FSM. Using the FSM state strobes, it latches the header byte, forwards header/payload/parity bytes to the output FIFOs on `dout`, and parks one byte while the target FIFO is full. It also accumulates packet parity and reports `parity_done`, `low_pkt_valid` and `err` back to the FSM and the top level.

## Interface
- `WIDTH`, 8, byte width of the data path
- `clk` in 1: single clock, all state updates on rising edge
- `resetn` in 1: synchronous, active-low reset
- `pkt_valid` in 1: source packet-valid; low during the parity byte
- `data_in` in WIDTH: source byte; header is `[7:2]` length and `[1:0]` address
- `fifo_full` in 1: selected destination FIFO full
- `detect_addr`, `ld_state`, `laf_state`, `full_state`, `lfd_state`, `rst_int_reg` in 1 each: FSM state strobes, one-hot, at most one high
- `dout` out WIDTH: byte presented to the FIFO write port
- `parity_done` out 1: parity byte captured
- `low_pkt_valid` out 1: `pkt_valid` fell while loading
- `err` out 1: packet parity mismatch

## Operation
- **Reset** (`resetn`=0 at an edge): `dout`, `parity_done`, `low_pkt_valid`, `err` and all internal registers (header, hold, internal parity, packet parity) go to 0. This applies mid-packet too.
- **Header capture:** `detect_addr && pkt_valid` → header ← `data_in`, and `err` ← 0.
- **Internal parity:**
  - `detect_addr` → 0.
  - `lfd_state` → internal parity ^ header.
  - `ld_state && pkt_valid` → internal parity ^ `data_in`. This applies whether or not `fifo_full` is high.
- **`dout` priority order:**
  - `lfd_state` → header.
  - `ld_state && !fifo_full` → `data_in`.
  - `laf_state` → hold.
  - Otherwise `dout` holds.
- **Hold register:** `ld_state && fifo_full` → hold ← `data_in`. `dout` is unchanged in that cycle. This prevents losing the byte the source believes was accepted.
- **`low_pkt_valid`:** set on `ld_state && !pkt_valid`. Cleared on `rst_int_reg`. If both are true in the same cycle, clear wins.
- **`parity_done` and packet-parity capture:**
  - A: `ld_state && !fifo_full && !pkt_valid` → packet parity ← `data_in`, `parity_done` ← 1.
  - B: `laf_state && low_pkt_valid && !parity_done` → packet parity ← hold, `parity_done` ← 1.
  - `detect_addr` → `parity_done` ← 0.
- **Error check:** `rst_int_reg && parity_done` → `err` ← (internal parity != packet parity). `err` is then held until the next header capture.
- **Soft resets** exist only in the FSM. They force it to `decode_address`, and this block clears via `detect_addr`. No extra port is needed.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- A byte loaded into `dout` at edge N is written by the FIFO on `we_reg` in cycle N+1.
  - Header: loaded at the end of `lfd_state`, written in the first `ld_state` cycle.
  - Parity byte: loaded at the end of the last `ld_state`, written in `load_parity`.
- `parity_done` is visible one cycle after condition A or B. The FSM samples it in `laf_state`. Condition B requires `!parity_done`, so the byte is never captured twice.
- `err` becomes valid the cycle after `check_parity` and is stable through `decode_address`.
- Full detour: ld(full) → full_state (`dout` held) → laf (`dout` ← hold) → ld or load_parity. The hold byte is written in the cycle after `laf_state`.

## Structure
- Shared `router_pkg` contains:
  - `WIDTH` default.
  - Header field positions (`ADDR_LSB`=0, `ADDR_MSB`=1, `LEN_LSB`=2).
  - The FSM state encoding constants, shared with the FSM.
- One sub-module, `router_parity_chk`: internal/packet parity registers, `parity_done`, `err`.
- `router_reg` keeps the header, hold, `dout` and `low_pkt_valid` logic.

## Test plan
- **Clean packet:** header 8'h09 (length 2, address 01), payload A1, B2, parity 1A, no full.
  - Required: `dout` sequence 09, A1, B2, 1A; `parity_done` 1 after the parity cycle; `err`=0.
- **Bad parity:** same packet with parity 1B.
  - Required: `err`=1 the cycle after `rst_int_reg`; `err` stays 1 until the next header with `pkt_valid`, then 0.
- **Full mid-payload:** `fifo_full` high during the ld cycle carrying A1, then full_state ×3, then laf.
  - Required: `dout` stays 09 through full_state; `dout`=A1 after laf; parity still 1A; `err`=0.
- **Full on parity byte:** `fifo_full` high in the ld cycle with `pkt_valid`=0 and data 1A.
  - Required: `low_pkt_valid`=1; `parity_done` stays 0 until laf, then 1; packet parity =1A.
- **Reset mid-payload:** `resetn`=0 for one edge during ld.
  - Required: all outputs 0 next cycle; the next packet 8'h05, 3C, parity 39 completes with `err`=0.
- **`low_pkt_valid` clear:** `rst_int_reg` pulse → `low_pkt_valid` 0 next cycle.
